// File: rtl/mode_sequencer.sv
// Mode sequencer for the sum / multiply / Gray-counter display datapath.
// Debounces the button, captures operands and steps WAIT -> SUM -> MUL -> GRAY.
module mode_sequencer #(
  parameter int unsigned DWELL_CYCLES    = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_DIV       = 8
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       btn,
  input  logic       auto_mode,
  input  logic [2:0] x1,
  input  logic [2:0] x2,
  input  logic [3:0] sum_res,
  input  logic [5:0] mul_res,
  input  logic [3:0] gray_val,
  output logic [2:0] op_a,
  output logic [2:0] op_b,
  output logic       gray_en,
  output logic       gray_clr,
  output logic [1:0] mode,
  output logic       busy,
  output logic [7:0] y
);

  localparam int unsigned DW  = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BW  = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_SUM  = 2'd1,
    ST_MUL  = 2'd2,
    ST_GRAY = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DBW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;
  logic [2:0]       op_a_q, op_a_d;
  logic [2:0]       op_b_q, op_b_d;
  logic             gray_en_q, gray_en_d;
  logic             gray_clr_q, gray_clr_d;
  logic             busy_q, busy_d;
  logic [7:0]       y_q, y_d;

  logic             btn_evt_c;
  logic             dwell_done_c;
  state_t           adv_state_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_WAIT;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_cnt_q   <= '0;
      dwell_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      gray_en_q   <= 1'b0;
      gray_clr_q  <= 1'b0;
      busy_q      <= 1'b0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      dwell_q     <= dwell_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      gray_en_q   <= gray_en_d;
      gray_clr_q  <= gray_clr_d;
      busy_q      <= busy_d;
      y_q         <= y_d;
    end
  end

  // Next-state, debounce, blink and output logic
  always_comb begin
    state_d     = state_q;
    sync1_d     = btn;
    sync2_d     = sync1_q;
    deb_cnt_d   = deb_cnt_q;
    dwell_d     = dwell_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    y_d         = '0;

    // Counter saturates at DEBOUNCE_CYCLES, so a held button hits the event value once
    btn_evt_c = sync2_q && (deb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1));
    if (!sync2_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DBW'(DEBOUNCE_CYCLES)) begin
      deb_cnt_d = deb_cnt_q + DBW'(1);
    end

    dwell_done_c = (dwell_q == DW'(DWELL_CYCLES - 1));
    adv_state_c  = state_t'(2'(state_q) + 2'd1);

    case (state_q)
      ST_WAIT: begin
        if (btn_evt_c) state_d = ST_SUM;
      end
      ST_SUM, ST_MUL, ST_GRAY: begin
        if (!auto_mode) begin
          if (btn_evt_c) state_d = adv_state_c;
        end else if (btn_evt_c) begin
          state_d = ST_WAIT;
        end else if (dwell_done_c) begin
          state_d = adv_state_c;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (state_d != state_q) dwell_d = '0;

    if (state_q == ST_WAIT && state_d == ST_SUM) begin
      op_a_d = x1;
      op_b_d = x2;
    end

    // Blink restarts low on each WAIT entry
    if (state_d == ST_WAIT && state_q != ST_WAIT) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    gray_clr_d = (state_d == ST_GRAY) && (state_q != ST_GRAY);
    gray_en_d  = (state_d == ST_GRAY) && (state_q == ST_GRAY);
    busy_d     = (state_d != ST_WAIT);

    case (state_q)
      ST_WAIT: y_d = {7'b0, blink_q};
      ST_SUM:  y_d = {4'b0, sum_res};
      ST_MUL:  y_d = {2'b0, mul_res};
      ST_GRAY: y_d = {4'b0, gray_val};
      default: y_d = '0;
    endcase
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign gray_en  = gray_en_q;
  assign gray_clr = gray_clr_q;
  assign mode     = 2'(state_q);
  assign busy     = busy_q;
  assign y        = y_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios plus random traffic against a
// cycle-level behavioural model of the sequencer and its datapath.
module tb_mode_sequencer;

  localparam int DWELL = 16;
  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic       clk = 1'b0;
  logic       srst, btn, auto_mode;
  logic [2:0] x1, x2;
  logic [3:0] sum_res;
  logic [5:0] mul_res;
  logic [3:0] gray_val;
  logic [2:0] op_a, op_b;
  logic       gray_en, gray_clr, busy;
  logic [1:0] mode;
  logic [7:0] y;
  logic [3:0] gbin;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode_sequencer #(.DWELL_CYCLES(DWELL), .DEBOUNCE_CYCLES(DEB), .BLINK_DIV(BLINK)) dut (
    .clk(clk), .srst(srst), .btn(btn), .auto_mode(auto_mode),
    .x1(x1), .x2(x2), .sum_res(sum_res), .mul_res(mul_res), .gray_val(gray_val),
    .op_a(op_a), .op_b(op_b), .gray_en(gray_en), .gray_clr(gray_clr),
    .mode(mode), .busy(busy), .y(y)
  );

  // Emulated arithmetic units and Gray counter
  assign sum_res  = 4'(op_a) + 4'(op_b);
  assign mul_res  = 6'(op_a) * 6'(op_b);
  assign gray_val = gbin ^ (gbin >> 1);

  always_ff @(posedge clk) begin
    if (srst || gray_clr) gbin <= 4'd0;
    else if (gray_en)     gbin <= gbin + 4'd1;
  end

  // Reference model state
  int m_s1, m_s2, m_run, m_phase, m_dwell, m_wticks;
  int m_opa, m_opb, m_y, m_clr, m_en, m_gcnt;

  function automatic int gray_of(int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic model_step();
    int evt, nph, ny;
    if (srst) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_phase = 0; m_dwell = 0; m_wticks = 0;
      m_opa = 0; m_opb = 0; m_y = 0; m_clr = 0; m_en = 0; m_gcnt = 0;
      return;
    end
    evt = (m_s2 != 0 && m_run + 1 == DEB) ? 1 : 0;
    case (m_phase)
      0:       ny = (m_wticks / BLINK) % 2;
      1:       ny = m_opa + m_opb;
      2:       ny = m_opa * m_opb;
      default: ny = gray_of(m_gcnt);
    endcase
    if (m_clr != 0)     m_gcnt = 0;
    else if (m_en != 0) m_gcnt = (m_gcnt + 1) % 16;
    nph = m_phase;
    if (m_phase == 0) begin
      if (evt != 0) begin
        nph = 1; m_opa = int'(x1); m_opb = int'(x2);
      end
    end else if (!auto_mode) begin
      if (evt != 0) nph = (m_phase + 1) % 4;
    end else if (evt != 0) begin
      nph = 0;
    end else if (m_dwell == DWELL - 1) begin
      nph = (m_phase + 1) % 4;
    end else begin
      m_dwell = m_dwell + 1;
    end
    if (nph != m_phase) m_dwell = 0;
    if (nph == 0) m_wticks = (m_phase == 0) ? m_wticks + 1 : 0;
    m_clr = (nph == 3 && m_phase != 3) ? 1 : 0;
    m_en  = (nph == 3 && m_phase == 3) ? 1 : 0;
    m_run = (m_s2 != 0) ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
    m_s2 = m_s1;
    m_s1 = int'(btn);
    m_y = ny;
    m_phase = nph;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model, let the DUT clock, then compare all outputs
  task automatic tick();
    logic [18:0] obs, exp;
    model_step();
    @(posedge clk);
    #1;
    obs = {mode, busy, y, op_a, op_b, gray_en, gray_clr};
    exp = {2'(m_phase), (m_phase != 0), 8'(m_y), 3'(m_opa), 3'(m_opb), 1'(m_en), 1'(m_clr)};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL cycle @%0t {mode,busy,y,op_a,op_b,en,clr}: observed %h expected %h", $time, obs, exp);
    end
  endtask

  task automatic press(input int hi, input int lo);
    btn = 1'b1;
    repeat (hi) tick();
    btn = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    int hold, found, n, cnt_sum, cnt_mul, cnt_en, cnt_gray, clr_seen;
    logic prev;
    srst = 1'b1; btn = 1'b0; auto_mode = 1'b0; x1 = '0; x2 = '0;
    m_s1 = 0; m_s2 = 0; m_run = 0; m_phase = 0; m_dwell = 0; m_wticks = 0;
    m_opa = 0; m_opb = 0; m_y = 0; m_clr = 0; m_en = 0; m_gcnt = 0;
    repeat (3) tick();
    srst = 1'b0;

    // Random traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn  = ~btn;
        hold = int'($urandom_range(1, 25));
      end
      hold--;
      x1 = 3'($urandom);
      x2 = 3'($urandom);
      if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
      srst = ($urandom_range(0, 699) == 0);
      tick();
    end

    // Reset from an arbitrary state
    srst = 1'b1; btn = 1'b0;
    repeat (3) tick();
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_y", 32'(y), 32'h00);
    chk("rst_gray_en", 32'(gray_en), 32'd0);
    chk("rst_ops", 32'({op_a, op_b}), 32'd0);
    srst = 1'b0; auto_mode = 1'b0;
    repeat (2) tick();

    // Debounce and manual stepping
    press(3, 6);
    chk("short_press", 32'(mode), 32'd0);
    x1 = 3'd5; x2 = 3'd6;
    press(20, 6);
    chk("man_sum_mode", 32'(mode), 32'd1);
    chk("man_sum_y", 32'(y), 32'h0B);
    x1 = 3'd7;
    repeat (3) tick();
    chk("man_sum_hold", 32'(y), 32'h0B);
    chk("man_op_a", 32'(op_a), 32'd5);
    press(8, 4);
    chk("man_mul_mode", 32'(mode), 32'd2);
    chk("man_mul_y", 32'(y), 32'h1E);
    press(8, 6);
    chk("man_gray_mode", 32'(mode), 32'd3);
    press(8, 6);
    chk("man_wait_mode", 32'(mode), 32'd0);

    // Timed auto sequence
    auto_mode = 1'b1; x1 = 3'd7; x2 = 3'd7;
    cnt_sum = 0; cnt_mul = 0; cnt_en = 0; cnt_gray = 0;
    btn = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i == 6) btn = 1'b0;
      tick();
      if (y == 8'h0E && (mode == 2'd1 || mode == 2'd2)) cnt_sum++;
      if (y == 8'h31) cnt_mul++;
      if (mode == 2'd3) cnt_gray++;
      if (gray_en) cnt_en++;
    end
    chk("auto_sum_cycles", 32'(cnt_sum), 32'd16);
    chk("auto_mul_cycles", 32'(cnt_mul), 32'd16);
    chk("auto_gray_cycles", 32'(cnt_gray), 32'd16);
    chk("auto_gray_en", 32'(cnt_en), 32'd15);
    chk("auto_end_mode", 32'(mode), 32'd0);
    chk("auto_end_busy", 32'(busy), 32'd0);

    // Abort coinciding with MUL dwell expiry
    found = 0;
    btn = 1'b1;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (i == 6) btn = 1'b0;
      tick();
      if (mode == 2'd2) found = 1;
    end
    btn = 1'b0;
    chk("reach_mul", 32'(found), 32'd1);
    repeat (10) tick();
    btn = 1'b1;
    clr_seen = 0;
    repeat (6) begin
      tick();
      if (gray_clr) clr_seen = 1;
    end
    chk("abort_mode", 32'(mode), 32'd0);
    btn = 1'b0;
    repeat (4) begin
      tick();
      if (gray_clr) clr_seen = 1;
    end
    chk("abort_no_clr", 32'(clr_seen), 32'd0);

    // Blink period in WAIT
    repeat (3) tick();
    prev = y[0];
    n = 0;
    while (y[0] == prev && n < 20) begin
      tick();
      n++;
    end
    chk("blink_first", 32'(n < 20), 32'd1);
    for (int k = 0; k < 2; k++) begin
      prev = y[0];
      n = 0;
      while (y[0] == prev && n < 20) begin
        tick();
        n++;
      end
      chk("blink_period", 32'(n), 32'd8);
      chk("blink_upper", 32'(y[7:1]), 32'd0);
    end

    // Reset in the middle of GRAY
    found = 0;
    btn = 1'b1;
    for (int i = 0; i < 80 && found == 0; i++) begin
      if (i == 6) btn = 1'b0;
      tick();
      if (mode == 2'd3) found = 1;
    end
    btn = 1'b0;
    chk("reach_gray", 32'(found), 32'd1);
    repeat (3) tick();
    srst = 1'b1;
    tick();
    chk("gray_rst_mode", 32'(mode), 32'd0);
    chk("gray_rst_y", 32'(y), 32'd0);
    chk("gray_rst_en", 32'(gray_en), 32'd0);
    srst = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Controller for the sum / multiply / Gray-counter display datapath.
- Debounces the user button, captures operands, and sequences the datapath through WAIT -> SUM -> MUL -> GRAY, either by manual button steps or by timed auto-advance.
- Drives the Gray counter enables and muxes the selected result onto the 8-bit LED output.
- Sits between board I/O and the arithmetic/Gray units.

Parameters:
- DWELL_CYCLES, 16: cycles each non-WAIT phase is held in auto mode (>=2).
- DEBOUNCE_CYCLES, 4: consecutive stable-high synced cycles needed to accept a press (>=1).
- BLINK_DIV, 8: WAIT-state blink half-period in cycles (>=1).

Ports:
- clk  in  1  system clock
- srst  in  1  synchronous active-high reset
- btn  in  1  raw asynchronous push-button
- auto_mode  in  1  1 = timed auto-advance, 0 = manual stepping
- x1  in  3  operand A source
- x2  in  3  operand B source
- sum_res  in  4  combinational op_a+op_b from sum unit
- mul_res  in  6  combinational op_a*op_b from mul unit
- gray_val  in  4  current Gray counter value
- op_a  out  3  captured operand A to sum/mul units
- op_b  out  3  captured operand B to sum/mul units
- gray_en  out  1  Gray counter count enable
- gray_clr  out  1  Gray counter clear pulse
- mode  out  2  current state: 0 WAIT, 1 SUM, 2 MUL, 3 GRAY
- busy  out  1  high when mode != 0
- y  out  8  registered LED output

Behaviour:
- Reset (srst=1 at posedge): next cycle all of the following hold: state=WAIT, mode=0, busy=0, y=0, op_a=0, op_b=0, gray_en=0, gray_clr=0, blink=0, all counters 0, sync flops 0. Reset mid-operation aborts immediately, with no completion of the current phase.
- Button path:
  - 2-flop synchronizer, then a stable-high counter.
  - btn_evt is a single-cycle pulse, issued when the synced level has been high for DEBOUNCE_CYCLES consecutive cycles after having been low.
  - Holding the button produces exactly one event; release (synced low) re-arms.
  - Shorter highs produce no event.
- Manual mode (auto_mode=0): each btn_evt advances WAIT->SUM->MUL->GRAY->WAIT. No other transitions.
- Auto mode (auto_mode=1):
  - WAIT: btn_evt -> SUM.
  - SUM/MUL/GRAY: dwell counter cleared on state entry and increments each cycle.
  - When the counter is at DWELL_CYCLES-1: SUM->MUL, MUL->GRAY, GRAY->WAIT.
  - btn_evt while in SUM/MUL/GRAY aborts to WAIT.
  - btn_evt and dwell expiry in the same cycle: abort wins (WAIT).
- auto_mode changes take effect the same cycle:
  - Switching to manual freezes the phase; the dwell counter holds.
  - Switching back to auto resumes the count.
- Operand capture:
  - On the WAIT->SUM transition edge: op_a<=x1, op_b<=x2.
  - Held constant until the next WAIT->SUM; x1/x2 changes mid-sequence are ignored.
- Gray control:
  - gray_clr is a 1-cycle pulse in the first cycle of GRAY.
  - gray_en=1 in every GRAY cycle after the first; 0 otherwise.
- Output y is registered from the current state, so y lags a state change by 1 cycle:
  - WAIT: {7'b0, blink}. blink is cleared on WAIT entry and toggles every BLINK_DIV cycles while in WAIT.
  - SUM: {4'b0, sum_res}.
  - MUL: {2'b0, mul_res}. Full 6-bit product, no truncation.
  - GRAY: {4'b0, gray_val}.
- mode and busy are registered state outputs, valid the cycle after the transition edge.
- Illegal state encoding: recover to WAIT on the next cycle.

Test Plan:
- Reset: assert srst for 3 cycles from random state -> mode=0, busy=0, y=8'h00, gray_en=0, op_a=op_b=0.
- Debounce: manual; btn high 3 cycles then low -> mode stays 0. btn high 20 cycles -> exactly one advance, mode=1. Second press needs a release first.
- Manual sequence: x1=5, x2=6:
  - press -> mode=1, y=8'h0B.
  - set x1=7 -> y stays 8'h0B.
  - press -> mode=2, y=8'h1E.
  - press -> mode=3, gray_clr 1-cycle pulse, y tracks gray_val.
  - press -> mode=0.
- Auto sequence: auto_mode=1, x1=7, x2=7, one press:
  - SUM 16 cycles with y=8'h0E.
  - MUL 16 cycles with y=8'h31.
  - GRAY 16 cycles with gray_en high 15 cycles.
  - Then mode=0, busy=0.
- Abort collision: auto; btn_evt aligned to the MUL dwell-expiry cycle -> next mode=0 (not 3), gray_clr never asserted.
- Blink/reset: in WAIT, y[0] toggles every 8 cycles and y[7:1]=0. srst asserted mid-GRAY -> next cycle mode=0, y=0, gray_en=0.
